// File: rtl/rf_hop_gate.sv
// Purpose : radio front-end hop/settle gate that models PLL settle time and releases TX/RX bits only while locked.
// Latency : TX/RX paths are 1 cycle; lock asserts N*CLK_PER_US+1 cycles after the loading pulse (N = settle time in us).
// Backpressure: none; bits outside a valid locked window are dropped and their outputs are forced to 0.
//
// Ports:
//   clk_6M, rstz                     - 6 MHz clock, asynchronous active-low reset
//   regi_pllsetuptime, loadfreq_p, k - settle time (us) and channel, captured on the load pulse
//   txen, txbitin                    - TX window and baseband bit   -> txbitout / txvalid
//   rxen, peer_txbit, peer_k, peer_txvalid - RX window and peer air signal -> rxbitout / rxvalid
//   stable_k, locked                 - locked channel and lock status
//   relock_cnt                       - saturating count of loads that interrupted a settle
module rf_hop_gate #(
  parameter int CLK_PER_US = 6,
  parameter int KW         = 7
) (
  input  logic          clk_6M,
  input  logic          rstz,
  input  logic [9:0]    regi_pllsetuptime,
  input  logic          loadfreq_p,
  input  logic [KW-1:0] k,
  input  logic          txen,
  input  logic          rxen,
  input  logic          txbitin,
  input  logic          peer_txbit,
  input  logic [KW-1:0] peer_k,
  input  logic          peer_txvalid,
  output logic          txbitout,
  output logic          txvalid,
  output logic          rxbitout,
  output logic          rxvalid,
  output logic [KW-1:0] stable_k,
  output logic          locked,
  output logic [7:0]    relock_cnt
);

  // A single-cycle microsecond still needs a 1-bit prescaler to keep widths legal.
  localparam int            PW       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state;
  logic [KW-1:0] pend_k;
  logic [9:0]    settle_us;
  logic [PW-1:0] pre;
  logic [9:0]    us_cnt;

  // Settle sequencer. A load pulse always wins, from any state, and restarts
  // the settle from zero. The us counter is compared every cycle, so it can
  // never run past settle_us and wrap.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state      <= IDLE;
      pend_k     <= '0;
      settle_us  <= '0;
      pre        <= '0;
      us_cnt     <= '0;
      stable_k   <= '0;
      locked     <= 1'b0;
      relock_cnt <= '0;
    end else if (loadfreq_p) begin
      pend_k    <= k;
      settle_us <= regi_pllsetuptime;
      pre       <= '0;
      us_cnt    <= '0;
      locked    <= 1'b0;
      state     <= SETTLE;
      if ((state == SETTLE) && (relock_cnt != 8'hFF)) begin
        relock_cnt <= relock_cnt + 8'd1;
      end
    end else begin
      case (state)
        SETTLE: begin
          if (us_cnt == settle_us) begin
            stable_k <= pend_k;
            locked   <= 1'b1;
            state    <= LOCKED;
          end else if (pre == PRE_LAST) begin
            pre    <= '0;
            us_cnt <= us_cnt + 10'd1;
          end else begin
            pre <= pre + PW'(1);
          end
        end
        default: begin
          // IDLE and LOCKED hold until the next load pulse.
        end
      endcase
    end
  end

  // Gates use the pre-edge lock, so a load coinciding with a window still
  // passes that one bit; valids drop from the following cycle.
  logic tx_hit;
  logic rx_hit;

  assign tx_hit = locked & txen;
  assign rx_hit = locked & rxen & peer_txvalid & (peer_k == stable_k);

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      txvalid  <= 1'b0;
      txbitout <= 1'b0;
      rxvalid  <= 1'b0;
      rxbitout <= 1'b0;
    end else begin
      txvalid  <= tx_hit;
      txbitout <= tx_hit & txbitin;
      rxvalid  <= rx_hit;
      rxbitout <= rx_hit & peer_txbit;
    end
  end

endmodule

// File: tb/tb_rf_hop_gate.sv
// Bench for rf_hop_gate: two cross-connectable instances (0 = master, 1 = slave),
// a deadline-based reference model, a per-cycle compare process and directed
// scenarios with literal expectations, followed by a randomized phase.
module tb_rf_hop_gate;

  localparam int CLK = 6;

  logic clk_6M = 1'b0;
  logic rstz   = 1'b0;
  logic xconn  = 1'b0;

  always #5 clk_6M = ~clk_6M;

  // Bench-driven inputs, per instance
  logic [9:0] setup [2];
  logic       loadp [2];
  logic [6:0] k_in  [2];
  logic [6:0] pk_in [2];
  logic       txen  [2];
  logic       rxen  [2];
  logic       txb   [2];
  logic       ptb   [2];
  logic       ptv   [2];

  // DUT outputs
  logic       txbo [2];
  logic       txv  [2];
  logic       rxbo [2];
  logic       rxv  [2];
  logic [6:0] sk   [2];
  logic       lk   [2];
  logic [7:0] rc   [2];

  // Peer inputs: either bench-driven or the other instance's air outputs
  logic [6:0] pk_mux  [2];
  logic       ptb_mux [2];
  logic       ptv_mux [2];

  assign pk_mux[0]  = xconn ? sk[1]   : pk_in[0];
  assign ptb_mux[0] = xconn ? txbo[1] : ptb[0];
  assign ptv_mux[0] = xconn ? txv[1]  : ptv[0];
  assign pk_mux[1]  = xconn ? sk[0]   : pk_in[1];
  assign ptb_mux[1] = xconn ? txbo[0] : ptb[1];
  assign ptv_mux[1] = xconn ? txv[0]  : ptv[1];

  rf_hop_gate u_m (
    .clk_6M(clk_6M), .rstz(rstz),
    .regi_pllsetuptime(setup[0]), .loadfreq_p(loadp[0]), .k(k_in[0]),
    .txen(txen[0]), .rxen(rxen[0]), .txbitin(txb[0]),
    .peer_txbit(ptb_mux[0]), .peer_k(pk_mux[0]), .peer_txvalid(ptv_mux[0]),
    .txbitout(txbo[0]), .txvalid(txv[0]), .rxbitout(rxbo[0]), .rxvalid(rxv[0]),
    .stable_k(sk[0]), .locked(lk[0]), .relock_cnt(rc[0])
  );

  rf_hop_gate u_s (
    .clk_6M(clk_6M), .rstz(rstz),
    .regi_pllsetuptime(setup[1]), .loadfreq_p(loadp[1]), .k(k_in[1]),
    .txen(txen[1]), .rxen(rxen[1]), .txbitin(txb[1]),
    .peer_txbit(ptb_mux[1]), .peer_k(pk_mux[1]), .peer_txvalid(ptv_mux[1]),
    .txbitout(txbo[1]), .txvalid(txv[1]), .rxbitout(rxbo[1]), .rxvalid(rxv[1]),
    .stable_k(sk[1]), .locked(lk[1]), .relock_cnt(rc[1])
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Lock is expressed as an absolute deadline edge: load at edge t with
  // N us locks at edge t + 1 + N*CLK, unless another load comes first.
  longint   ecount = 0;
  longint   dl      [2];
  bit       settling[2];
  bit [6:0] m_pend  [2];
  bit [6:0] m_stab  [2];
  bit       m_lock  [2];
  int       m_rc    [2];
  bit       m_txv   [2];
  bit       m_txb   [2];
  bit       m_rxv   [2];
  bit       m_rxb   [2];
  // pre-edge snapshots
  bit       o_txv   [2];
  bit       o_txb   [2];
  bit [6:0] o_stab  [2];
  bit       o_lock  [2];

  always @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      for (int i = 0; i < 2; i++) begin
        settling[i] = 1'b0; m_pend[i] = '0; m_stab[i] = '0; m_lock[i] = 1'b0;
        m_rc[i] = 0; m_txv[i] = 1'b0; m_txb[i] = 1'b0; m_rxv[i] = 1'b0; m_rxb[i] = 1'b0;
        dl[i] = 0;
      end
    end else begin
      ecount++;
      for (int i = 0; i < 2; i++) begin
        o_txv[i] = m_txv[i]; o_txb[i] = m_txb[i]; o_stab[i] = m_stab[i]; o_lock[i] = m_lock[i];
      end
      for (int i = 0; i < 2; i++) begin
        bit       pv;
        bit       pb;
        bit [6:0] pk;
        pv = xconn ? o_txv[1-i]  : ptv[i];
        pb = xconn ? o_txb[1-i]  : ptb[i];
        pk = xconn ? o_stab[1-i] : pk_in[i];
        m_txv[i] = o_lock[i] && txen[i];
        m_txb[i] = m_txv[i] && txb[i];
        m_rxv[i] = o_lock[i] && rxen[i] && pv && (pk == o_stab[i]);
        m_rxb[i] = m_rxv[i] && pb;
        if (loadp[i]) begin
          if (settling[i] && m_rc[i] < 255) m_rc[i] = m_rc[i] + 1;
          m_pend[i]   = k_in[i];
          dl[i]       = ecount + 1 + longint'(setup[i]) * CLK;
          settling[i] = 1'b1;
          m_lock[i]   = 1'b0;
        end else if (settling[i] && ecount == dl[i]) begin
          m_lock[i]   = 1'b1;
          m_stab[i]   = m_pend[i];
          settling[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk_6M) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [19:0] act;
      logic [19:0] exp;
      act = {txbo[i], txv[i], rxbo[i], rxv[i], sk[i], lk[i], rc[i]};
      exp = {m_txb[i], m_txv[i], m_rxb[i], m_rxv[i], m_stab[i], m_lock[i], 8'(m_rc[i])};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL model_cmp inst%0d edge=%0d act=%h exp=%h {txb,txv,rxb,rxv,k,lock,rc}",
                 i, ecount, act, exp);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk_6M);
  endtask

  task automatic sample();
    @(posedge clk_6M);
    #1;
  endtask

  // Call right after a negedge; the load is sampled at the next posedge.
  task automatic pulse(input int i, input logic [6:0] kk, input logic [9:0] n);
    k_in[i]  = kk;
    setup[i] = n;
    loadp[i] = 1'b1;
    @(negedge clk_6M);
    loadp[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int bad;
    int lat;
    logic b;
    logic en;
    logic d;
    logic prev_en;
    logic prev_d;

    for (int i = 0; i < 2; i++) begin
      setup[i] = '0; loadp[i] = 1'b0; k_in[i] = '0; pk_in[i] = '0;
      txen[i] = 1'b0; rxen[i] = 1'b0; txb[i] = 1'b0; ptb[i] = 1'b0; ptv[i] = 1'b0;
    end

    // Reset state
    nclk(3);
    chk("reset_outputs_m", 32'({txbo[0], txv[0], rxbo[0], rxv[0], sk[0], lk[0], rc[0]}), 0);
    chk("reset_outputs_s", 32'({txbo[1], txv[1], rxbo[1], rxv[1], sk[1], lk[1], rc[1]}), 0);
    rstz = 1'b1;
    nclk(2);

    // 150 us settle on k=23: 900 edges unlocked, lock on edge 901
    pulse(0, 7'd23, 10'd150);
    txen[0] = 1'b1;
    txb[0]  = 1'b1;
    bad = 0;
    repeat (900) begin
      sample();
      if (lk[0] !== 1'b0 || txv[0] !== 1'b0 || txbo[0] !== 1'b0) bad++;
    end
    chk("t1_prelock_quiet_cycles", bad, 0);
    sample();
    chk("t1_locked", 32'(lk[0]), 1);
    chk("t1_stable_k", 32'(sk[0]), 23);
    chk("t1_model_lock", 32'(m_lock[0]), 1);

    // Zero settle on k=5, alternating TX bits
    @(negedge clk_6M);
    pulse(0, 7'd5, 10'd0);
    sample();
    chk("t2_locked_next_edge", 32'(lk[0]), 1);
    chk("t2_stable_k", 32'(sk[0]), 5);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_6M);
      b = (c % 2 == 0);
      txb[0] = b;
      sample();
      chk("t2_txbitout", 32'(txbo[0]), 32'(b));
      chk("t2_txvalid", 32'(txv[0]), 1);
    end

    // RX channel match / mismatch on k=40
    @(negedge clk_6M);
    txen[0] = 1'b0;
    pulse(0, 7'd40, 10'd0);
    rxen[0] = 1'b1; ptv[0] = 1'b1; ptb[0] = 1'b1; pk_in[0] = 7'd40;
    sample();
    @(negedge clk_6M);
    sample();
    chk("t3_rxvalid_match", 32'(rxv[0]), 1);
    chk("t3_rxbit_match", 32'(rxbo[0]), 1);
    @(negedge clk_6M);
    pk_in[0] = 7'd41;
    sample();
    chk("t3_rxvalid_mismatch", 32'(rxv[0]), 0);
    chk("t3_rxbit_mismatch", 32'(rxbo[0]), 0);
    @(negedge clk_6M);
    rxen[0] = 1'b0; ptv[0] = 1'b0; ptb[0] = 1'b0;

    // Relock 30 cycles into a 10 us settle
    pulse(0, 7'd7, 10'd10);
    nclk(29);
    pulse(0, 7'd9, 10'd10);
    sample();
    chk("t4_relock_cnt", 32'(rc[0]), 1);
    lat = 1;
    while (lk[0] !== 1'b1 && lat < 200) begin
      sample();
      lat++;
    end
    chk("t4_lock_latency", lat, 61);
    chk("t4_stable_k", 32'(sk[0]), 9);
    @(negedge clk_6M);
    repeat (300) pulse(0, 7'd9, 10'd10);
    sample();
    chk("t4_relock_saturated", 32'(rc[0]), 255);
    chk("t4_model_relock", 32'(m_rc[0]), 255);

    // Asynchronous reset 200 cycles into a 150 us settle
    @(negedge clk_6M);
    txen[0] = 1'b1; txb[0] = 1'b1;
    pulse(0, 7'd3, 10'd150);
    nclk(199);
    @(posedge clk_6M);
    #2;
    rstz = 1'b0;
    #1;
    chk("t5_async_clear_m", 32'({txbo[0], txv[0], rxbo[0], rxv[0], sk[0], lk[0], rc[0]}), 0);
    chk("t5_async_clear_s", 32'({txbo[1], txv[1], rxbo[1], rxv[1], sk[1], lk[1], rc[1]}), 0);
    nclk(2);
    rstz = 1'b1;
    bad = 0;
    repeat (1000) begin
      sample();
      if (lk[0] !== 1'b0 || lk[1] !== 1'b0) bad++;
    end
    chk("t5_no_lock_after_reset", bad, 0);

    // Cross-connected pair on k=12, master TX with a random window pattern
    @(negedge clk_6M);
    txen[0] = 1'b0; txb[0] = 1'b0;
    xconn = 1'b1;
    rxen[1] = 1'b1;
    k_in[0] = 7'd12; k_in[1] = 7'd12; setup[0] = 10'd1; setup[1] = 10'd1;
    loadp[0] = 1'b1; loadp[1] = 1'b1;
    @(negedge clk_6M);
    loadp[0] = 1'b0; loadp[1] = 1'b0;
    nclk(10);
    prev_en = 1'b0;
    prev_d  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_6M);
      en = 1'($urandom);
      d  = 1'($urandom);
      txen[0] = en;
      txb[0]  = d;
      sample();
      chk("t6_slave_rxbit", 32'(rxbo[1]), 32'(prev_en & prev_d));
      chk("t6_slave_rxvalid", 32'(rxv[1]), 32'(prev_en));
      prev_en = en;
      prev_d  = d;
    end
    @(negedge clk_6M);
    txen[0] = 1'b1;
    pulse(1, 7'd13, 10'd0);
    bad = 0;
    repeat (50) begin
      @(negedge clk_6M);
      txb[0] = 1'($urandom);
      sample();
      if (rxv[1] !== 1'b0) bad++;
    end
    chk("t6_slave_offchannel_quiet", bad, 0);

    // Randomized phase, checked cycle by cycle against the model
    for (int blk = 0; blk < 30; blk++) begin
      @(negedge clk_6M);
      xconn = 1'($urandom);
      repeat (100) begin
        @(negedge clk_6M);
        for (int i = 0; i < 2; i++) begin
          loadp[i] = ($urandom_range(0, 19) == 0);
          setup[i] = 10'($urandom_range(0, 3));
          k_in[i]  = 7'($urandom_range(0, 3));
          pk_in[i] = 7'($urandom_range(0, 3));
          txen[i]  = 1'($urandom);
          rxen[i]  = 1'($urandom);
          txb[i]   = 1'($urandom);
          ptb[i]   = 1'($urandom);
          ptv[i]   = 1'($urandom);
        end
      end
    end
    @(negedge clk_6M);
    loadp[0] = 1'b0;
    loadp[1] = 1'b0;
    nclk(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_hop_gate.md
# rf_hop_gate

Synthesizable radio front-end hop/settle gate. It sits directly downstream of `bt_top` (`txbit`, `fk`, `txbit_period`, `rxbit_period`) and directly upstream of the air channel. On each frequency load it models the PLL settle time, and it releases TX and RX bits only once the synthesizer is locked and, for RX, only when the peer's channel matches. Two instances, one per device, replace the ad-hoc channel-equality gating between the master and slave links.

## Interface
Parameters:
- `CLK_PER_US`, default 6: clock cycles per microsecond (clock is 6 MHz).
- `KW`, default 7: channel index width.

Ports:
- `clk_6M`  in  1  system clock, 6 MHz.
- `rstz`  in  1  reset; asynchronous, active-low.
- `regi_pllsetuptime`  in  10  PLL settle time in µs. Sampled on `loadfreq_p`.
- `loadfreq_p`  in  1  one-cycle pulse: load a new frequency.
- `k`  in  KW  requested channel. Sampled on `loadfreq_p`.
- `txen`  in  1  TX window (`txbit_period`).
- `rxen`  in  1  RX window (`rxbit_period`).
- `txbitin`  in  1  baseband TX bit.
- `peer_txbit`  in  1  bit radiated by the peer device.
- `peer_k`  in  KW  peer's currently radiated channel.
- `peer_txvalid`  in  1  peer is radiating a valid bit.
- `txbitout`  out  1  bit radiated onto the air.
- `txvalid`  out  1  `txbitout` is valid.
- `rxbitout`  out  1  bit delivered to baseband `rxbit`.
- `rxvalid`  out  1  `rxbitout` is valid.
- `stable_k`  out  KW  locked channel.
- `locked`  out  1  PLL settled on `stable_k`.
- `relock_cnt`  out  8  count of loads that arrived during SETTLE. Saturates at 255.

## Operation
- States: IDLE, SETTLE, LOCKED. Reset state is IDLE.
- All outputs reset to 0: `txbitout`, `txvalid`, `rxbitout`, `rxvalid`, `stable_k`, `locked`, `relock_cnt`.
- Settle transitions:
  - Any state plus `loadfreq_p`: capture `k` into `pend_k` and `regi_pllsetuptime` into `settle_us`.
  - Clear the µs prescaler (0..CLK_PER_US-1) and the µs counter, deassert `locked`, then go to SETTLE.
  - If `loadfreq_p` arrives while in SETTLE, `relock_cnt` increments (saturating) and the settle restarts from zero.
- Settle completion:
  - In SETTLE, the prescaler wraps at CLK_PER_US-1 and increments the µs counter on each wrap.
  - When µs counter == `settle_us` (checked every cycle): load `stable_k`←`pend_k`, assert `locked`, go to LOCKED.
  - `settle_us`=0 locks on the first SETTLE cycle.
- LOCKED holds until the next `loadfreq_p`. IDLE is left only by `loadfreq_p`.
- TX path, registered:
  - `txvalid` ← `locked & txen`.
  - `txbitout` ← `txbitin` when `locked & txen`, else 0.
- RX path, registered:
  - Hit condition: `locked & rxen & peer_txvalid & (peer_k==stable_k)`.
  - `rxvalid` ← hit condition.
  - `rxbitout` ← `peer_txbit` on a hit, else 0. No X is ever driven.
- Simultaneous `txen` and `rxen`: both paths are evaluated independently. There is no arbitration.
- `loadfreq_p` in the same cycle as a TX or RX window: the gate uses the pre-edge `locked`. From the next cycle, `locked`=0 and both valids drop.
- Reset mid-SETTLE returns to IDLE with all outputs cleared. No partial lock is retained.

## Timing
- `loadfreq_p` high at edge t:
  - `locked` is 0 from t+1.
  - With N=`settle_us`, `locked` and `stable_k` update at edge t+1+N·CLK_PER_US.
  - N=0 gives edge t+1.
- Example: N=150 gives 901 cycles, which is 150.17 µs.
- TX and RX outputs have one-cycle latency from `txen`/`rxen`/`txbitin`/`peer_*`.
- Prescaler width is ceil(log2(CLK_PER_US)). The µs counter is 10 bits and never wraps, because the compare against 10-bit `settle_us` is reached first.
- `relock_cnt` updates at the edge following the restarting `loadfreq_p`.

## Test plan
- Reset, then `loadfreq_p` with k=23 and setuptime=150. Required: `locked`=0 for 900 cycles, then `locked`=1 and `stable_k`=23 on cycle 901. Before that, `txen`=1 gives `txvalid`=0 and `txbitout`=0.
- Setuptime=0 with k=5. Required: `locked` at t+1. With `txen`=1, `txbitin` alternating 1/0: `txbitout` reproduces the pattern delayed by one cycle, and `txvalid`=1.
- Locked on k=40, `rxen`=1, `peer_txvalid`=1, `peer_txbit`=1:
  - `peer_k`=40: `rxvalid`=1 and `rxbitout`=1.
  - `peer_k`=41: `rxvalid`=0 and `rxbitout`=0, never X.
- Setuptime=10, second `loadfreq_p` (k=9) 30 cycles into the first. Required: `relock_cnt`=1, and lock arrives 61 cycles after the second pulse with `stable_k`=9. Repeat 300 times and check `relock_cnt` saturates at 255.
- Deassert `rstz` 200 cycles into a 150 µs settle. Required: all outputs 0 immediately (asynchronous). After release, no lock occurs without a new `loadfreq_p`.
- Two instances cross-connected, same k=12, setuptime=1. Master drives `txen` with a PRBS. Required: slave `rxbitout` equals master `txbitin` delayed by two cycles. With the slave on k=13, slave `rxvalid` stays 0.
